// File: rtl/matrix_pkg.sv
// Shared sizing, state encoding and slot/ID types for the matrix sequencer.
package matrix_pkg;

  localparam int WINSIZE  = 200;
  localparam int POPSIZE  = 100;
  localparam int ID_WIDTH = 11;

  localparam int EDGE_AW = $clog2(WINSIZE);
  localparam int SLOT_W  = $clog2(POPSIZE);
  localparam int CNT_W   = $clog2(POPSIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP_SRC,
    S_WAIT_SRC,
    S_RES_SRC,
    S_CMP_DST,
    S_WAIT_DST,
    S_RES_DST,
    S_SET_EDGE
  } seq_state_t;

  typedef logic [SLOT_W-1:0]   slot_idx_t;
  typedef logic [ID_WIDTH-1:0] id_t;
  typedef logic [CNT_W-1:0]    cnt_t;

endpackage

// File: rtl/matrix_penc.sv
// Lowest-index priority encoder over the element match vector; also flags
// when more than one element claims the same ID.
module matrix_penc #(
  parameter int N = 100,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         hit_o,
  output logic         multi_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = i[W-1:0];
    end
  end

  assign hit_o   = |req_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(req_i & (req_i - N'(1)));

endmodule

// File: rtl/matrix_seq.sv
// Edge-record sequencer for the matrix element array: resolves src/dst IDs
// to slots (allocating on miss) and sets the src row's dst column.
//
// state      | meaning
// S_IDLE     | ready for a record or a clear
// S_CMP_SRC  | broadcast src ID with compare strobe
// S_WAIT_SRC | wait for element compare pipeline
// S_RES_SRC  | resolve src slot: hit, allocate, or drop
// S_CMP_DST  | broadcast dst ID with compare strobe
// S_WAIT_DST | wait for element compare pipeline
// S_RES_DST  | resolve dst slot: hit, allocate, or drop
// S_SET_EDGE | report record done, strobe the edge bit unless dropped
module matrix_seq
  import matrix_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [ID_WIDTH-1:0] in_src_i,
  input  logic [ID_WIDTH-1:0] in_dst_i,
  input  logic                clear_i,
  output logic [ID_WIDTH-1:0] el_data_o,
  output logic                el_cmp_o,
  output logic [POPSIZE-1:0]  el_load_o,
  output logic                el_clr_o,
  output logic [POPSIZE-1:0]  el_edge_set_o,
  output logic [EDGE_AW-1:0]  el_edge_addr_o,
  input  logic [POPSIZE-1:0]  el_match_i,
  output logic                rec_done_o,
  output logic                rec_drop_o,
  output logic [SLOT_W-1:0]   src_idx_o,
  output logic [SLOT_W-1:0]   dst_idx_o,
  output logic [CNT_W-1:0]    pop_count_o,
  output logic                err_full_o,
  output logic                err_multi_o
);

  localparam logic [POPSIZE-1:0] ONE_HOT0 = POPSIZE'(1);

  seq_state_t         state_q;
  id_t                dst_cap_q;
  cnt_t               pop_q;
  slot_idx_t          src_q, dst_q;
  logic               rdy_q;
  logic [POPSIZE-1:0] edge_set_q;
  logic [EDGE_AW-1:0] edge_addr_q;
  id_t                el_data_q;
  logic               el_cmp_q, el_clr_q, rec_done_q, rec_drop_q;
  logic               err_full_q, err_multi_q;

  slot_idx_t m_idx;
  logic      m_hit, m_multi;
  logic      in_res, full, alloc;
  slot_idx_t res_idx;

  matrix_penc #(.N(POPSIZE), .W(SLOT_W)) u_penc (
    .req_i   (el_match_i),
    .idx_o   (m_idx),
    .hit_o   (m_hit),
    .multi_o (m_multi)
  );

  // Resolve-cycle decode; the load strobe must land in the same cycle the match is sampled.
  always_comb begin
    in_res  = (state_q == S_RES_SRC) || (state_q == S_RES_DST);
    full    = (pop_q == CNT_W'(POPSIZE));
    alloc   = in_res && !m_hit && !full;
    res_idx = m_hit ? m_idx : slot_idx_t'(pop_q);
  end

  assign el_load_o      = alloc ? (ONE_HOT0 << pop_q) : '0;
  // rdy_q is low under reset so in_ready stays 0 while rst_n is asserted.
  assign in_ready_o     = rdy_q && !clear_i;
  assign el_data_o      = el_data_q;
  assign el_cmp_o       = el_cmp_q;
  assign el_clr_o       = el_clr_q;
  assign el_edge_set_o  = edge_set_q;
  assign el_edge_addr_o = edge_addr_q;
  assign rec_done_o     = rec_done_q;
  assign rec_drop_o     = rec_drop_q;
  assign src_idx_o      = src_q;
  assign dst_idx_o      = dst_q;
  assign pop_count_o    = pop_q;
  assign err_full_o     = err_full_q;
  assign err_multi_o    = err_multi_q;

  // Sequencer FSM with registered strobes; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dst_cap_q   <= '0;
      pop_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rdy_q       <= 1'b0;
      edge_set_q  <= '0;
      edge_addr_q <= '0;
      el_data_q   <= '0;
      el_cmp_q    <= 1'b0;
      el_clr_q    <= 1'b0;
      rec_done_q  <= 1'b0;
      rec_drop_q  <= 1'b0;
      err_full_q  <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      el_cmp_q    <= 1'b0;
      el_clr_q    <= 1'b0;
      rec_done_q  <= 1'b0;
      rec_drop_q  <= 1'b0;
      edge_set_q  <= '0;
      edge_addr_q <= '0;
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (clear_i) begin
            el_clr_q    <= 1'b1;
            pop_q       <= '0;
            err_full_q  <= 1'b0;
            err_multi_q <= 1'b0;
          end else if (in_valid_i && rdy_q) begin
            el_data_q <= in_src_i;
            dst_cap_q <= in_dst_i;
            el_cmp_q  <= 1'b1;
            rdy_q     <= 1'b0;
            state_q   <= S_CMP_SRC;
          end
        end
        S_CMP_SRC:  state_q <= S_WAIT_SRC;
        S_WAIT_SRC: state_q <= S_RES_SRC;
        S_RES_SRC: begin
          if (m_hit || !full) begin
            src_q     <= res_idx;
            if (alloc) pop_q <= pop_q + CNT_W'(1);
            if (m_hit && m_multi) err_multi_q <= 1'b1;
            el_data_q <= dst_cap_q;
            el_cmp_q  <= 1'b1;
            state_q   <= S_CMP_DST;
          end else begin
            // Array full on src: dst is never looked up.
            src_q      <= '0;
            dst_q      <= '0;
            rec_done_q <= 1'b1;
            rec_drop_q <= 1'b1;
            err_full_q <= 1'b1;
            state_q    <= S_SET_EDGE;
          end
        end
        S_CMP_DST:  state_q <= S_WAIT_DST;
        S_WAIT_DST: state_q <= S_RES_DST;
        S_RES_DST: begin
          rec_done_q <= 1'b1;
          state_q    <= S_SET_EDGE;
          if (m_hit || !full) begin
            dst_q       <= res_idx;
            if (alloc) pop_q <= pop_q + CNT_W'(1);
            if (m_hit && m_multi) err_multi_q <= 1'b1;
            edge_set_q  <= ONE_HOT0 << src_q;
            edge_addr_q <= EDGE_AW'(res_idx);
          end else begin
            dst_q      <= '0;
            rec_drop_q <= 1'b1;
            err_full_q <= 1'b1;
          end
        end
        S_SET_EDGE: begin
          el_data_q <= '0;
          rdy_q     <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_seq.sv
module tb_matrix_seq;
  import matrix_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, clear;
  logic [ID_WIDTH-1:0] in_src, in_dst, el_data;
  logic el_cmp, el_clr, rec_done, rec_drop, err_full, err_multi;
  logic [POPSIZE-1:0] el_load, el_edge_set, el_match, force_vec;
  logic [EDGE_AW-1:0] el_edge_addr;
  logic [SLOT_W-1:0] src_idx, dst_idx;
  logic [CNT_W-1:0] pop_count;

  int n_cmp = 0;
  int n_fail = 0;

  matrix_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_src_i(in_src), .in_dst_i(in_dst), .clear_i(clear),
    .el_data_o(el_data), .el_cmp_o(el_cmp), .el_load_o(el_load),
    .el_clr_o(el_clr), .el_edge_set_o(el_edge_set), .el_edge_addr_o(el_edge_addr),
    .el_match_i(el_match), .rec_done_o(rec_done), .rec_drop_o(rec_drop),
    .src_idx_o(src_idx), .dst_idx_o(dst_idx), .pop_count_o(pop_count),
    .err_full_o(err_full), .err_multi_o(err_multi)
  );

  always #5 clk = ~clk;

  // Behavioural element array: latch on load, compare result appears 2 cycles after el_cmp.
  logic [ID_WIDTH-1:0] store [POPSIZE];
  logic [POPSIZE-1:0]  vld, m1, m2, cmp_vec;
  int load_cnt = 0, multi_load = 0, last_load = -1, strobe_cnt = 0;

  always_comb begin
    cmp_vec = '0;
    for (int i = 0; i < POPSIZE; i++) cmp_vec[i] = vld[i] && (store[i] == el_data);
  end
  assign el_match = m2 | force_vec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0; m1 <= '0; m2 <= '0;
    end else begin
      if (el_clr) vld <= '0;
      for (int i = 0; i < POPSIZE; i++)
        if (el_load[i]) begin store[i] <= el_data; vld[i] <= 1'b1; end
      m1 <= el_cmp ? cmp_vec : '0;
      m2 <= m1;
    end
  end

  always @(posedge clk) begin
    if (el_load != '0) begin
      load_cnt <= load_cnt + 1;
      if ($countones(el_load) > 1) multi_load <= multi_load + 1;
      for (int i = 0; i < POPSIZE; i++) if (el_load[i]) last_load <= i;
    end
    if (el_cmp || rec_done || el_edge_set != '0 || el_load != '0) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int k;
    k = 0;
    while (!in_ready && k < 20) begin tick; k++; end
    check("wait_ready", {127'b0, in_ready}, 128'd1);
  endtask

  int done_cyc, loads;
  logic r_drop;
  logic [SLOT_W-1:0] r_src, r_dst;
  logic [POPSIZE-1:0] r_set;
  logic [EDGE_AW-1:0] r_addr;

  // Sends one record; force_c > 0 injects bits 3 and 7 into el_match in that cycle.
  task automatic send(input logic [ID_WIDTH-1:0] s, input logic [ID_WIDTH-1:0] d, input int force_c);
    int lc0;
    wait_ready;
    lc0 = load_cnt;
    in_valid = 1'b1; in_src = s; in_dst = d;
    tick;
    in_valid = 1'b0; in_src = 11'h555; in_dst = 11'h2AA;
    done_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      if (c == force_c) force_vec = (POPSIZE'(1) << 3) | (POPSIZE'(1) << 7);
      else force_vec = '0;
      if (rec_done) begin
        done_cyc = c; r_drop = rec_drop; r_src = src_idx; r_dst = dst_idx;
        r_set = el_edge_set; r_addr = el_edge_addr;
        break;
      end
      tick;
    end
    force_vec = '0;
    loads = load_cnt - lc0;
  endtask

  task automatic do_clear;
    wait_ready;
    clear = 1'b1; in_valid = 1'b1; in_src = 11'h0AA; in_dst = 11'h0BB;
    #1;
    check("clear_blocks_ready", {127'b0, in_ready}, 128'd0);
    tick;
    clear = 1'b0; in_valid = 1'b0;
    check("clr_pulse", {127'b0, el_clr}, 128'd1);
    check("clr_no_cmp", {127'b0, el_cmp}, 128'd0);
    check("clr_pop", 128'(pop_count), 128'd0);
    tick;
    check("clr_pulse_end", {127'b0, el_clr}, 128'd0);
  endtask

  initial begin
    int s0;
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; in_src = '0; in_dst = '0; force_vec = '0;
    #12;
    check("rst_ready", {127'b0, in_ready}, 128'd0);
    check("rst_strobes", {124'b0, el_cmp, el_clr, rec_done, rec_drop}, 128'd0);
    check("rst_pop", 128'(pop_count), 128'd0);
    check("rst_err", {126'b0, err_full, err_multi}, 128'd0);
    tick;
    rst_n = 1'b1;
    tick; tick;

    // 1: two new IDs
    send(11'h123, 11'h456, 0);
    check("t1_done_cyc", 128'(done_cyc), 128'd7);
    check("t1_src", 128'(r_src), 128'd0);
    check("t1_dst", 128'(r_dst), 128'd1);
    check("t1_set", 128'(r_set), 128'd1);
    check("t1_addr", 128'(r_addr), 128'd1);
    check("t1_drop", {127'b0, r_drop}, 128'd0);
    check("t1_loads", 128'(loads), 128'd2);
    check("t1_pop", 128'(pop_count), 128'd2);
    tick;
    check("t1_ready_c8", {127'b0, in_ready}, 128'd1);

    // 2: both hit
    send(11'h456, 11'h123, 0);
    check("t2_src", 128'(r_src), 128'd1);
    check("t2_dst", 128'(r_dst), 128'd0);
    check("t2_set", 128'(r_set), 128'd2);
    check("t2_addr", 128'(r_addr), 128'd0);
    check("t2_loads", 128'(loads), 128'd0);
    check("t2_pop", 128'(pop_count), 128'd2);

    do_clear;

    // 3: self-loop on empty array
    send(11'h7FF, 11'h7FF, 0);
    check("t3_loads", 128'(loads), 128'd1);
    check("t3_load_slot", 128'(last_load), 128'd0);
    check("t3_src", 128'(r_src), 128'd0);
    check("t3_dst", 128'(r_dst), 128'd0);
    check("t3_set", 128'(r_set), 128'd1);
    check("t3_pop", 128'(pop_count), 128'd1);

    // 4: fill to capacity, then drops at src and at dst
    for (int k = 0; k < 49; k++) send(11'h100 + 11'(2 * k), 11'h101 + 11'(2 * k), 0);
    send(11'h200, 11'h200, 0);
    check("t4_pop_full", 128'(pop_count), 128'd100);
    check("t4_err_full_pre", {127'b0, err_full}, 128'd0);
    check("t4_no_multi_load", 128'(multi_load), 128'd0);
    send(11'h001, 11'h002, 0);
    check("t4_src_drop_cyc", 128'(done_cyc), 128'd4);
    check("t4_src_drop", {127'b0, r_drop}, 128'd1);
    check("t4_src_drop_set", 128'(r_set), 128'd0);
    check("t4_src_drop_loads", 128'(loads), 128'd0);
    tick;
    check("t4_err_full", {127'b0, err_full}, 128'd1);
    send(11'h100, 11'h003, 0);
    check("t4_dst_drop_cyc", 128'(done_cyc), 128'd7);
    check("t4_dst_drop", {127'b0, r_drop}, 128'd1);
    check("t4_dst_drop_src", 128'(r_src), 128'd1);
    check("t4_dst_drop_set", 128'(r_set), 128'd0);
    check("t4_pop_hold", 128'(pop_count), 128'd100);

    do_clear;
    check("t5_err_full_cleared", {127'b0, err_full}, 128'd0);

    // 5: two match bits at RES_SRC
    send(11'h010, 11'h020, 3);
    check("t5_src", 128'(r_src), 128'd3);
    check("t5_dst", 128'(r_dst), 128'd0);
    check("t5_set", 128'(r_set), 128'd8);
    check("t5_loads", 128'(loads), 128'd1);
    tick;
    check("t5_err_multi", {127'b0, err_multi}, 128'd1);
    check("t5_pop", 128'(pop_count), 128'd1);

    // 6: reset in WAIT_DST
    wait_ready;
    in_valid = 1'b1; in_src = 11'h050; in_dst = 11'h060;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    #1;
    check("t6_ready", {127'b0, in_ready}, 128'd0);
    check("t6_strobes", {124'b0, el_cmp, el_clr, rec_done, rec_drop}, 128'd0);
    check("t6_data", 128'(el_data), 128'd0);
    check("t6_load", 128'(el_load), 128'd0);
    check("t6_pop", 128'(pop_count), 128'd0);
    check("t6_err", {126'b0, err_full, err_multi}, 128'd0);
    check("t6_src", 128'(src_idx), 128'd0);
    tick; tick;
    rst_n = 1'b1;
    s0 = strobe_cnt;
    repeat (10) tick;
    check("t6_no_strobe", 128'(strobe_cnt - s0), 128'd0);
    do_clear;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
